// File: rtl/sparc_exu_ecl_tagcmp_pipe.sv
// ---------------------------------------------------------------------------
// sparc_exu_ecl_tagcmp_pipe
//
// Destination-tag tracking pipeline with multi-source compare for the EXU
// control logic. DEPTH in-flight destination tags (entry 0 = youngest) are
// held with valid bits. Each cycle, NSRC source tags are compared against
// every valid entry. The per-stage match vectors, a one-hot youngest-match
// select and a per-source hit flag are registered for bypass-mux selection
// and RAW-hazard detection.
//
// Ports:
//   clk        : clock, rising edge
//   arst_l     : asynchronous active-low reset
//   advance    : pipeline advances this cycle (0 = stall, entries hold)
//   flush      : invalidate every entry and zero the registered outputs
//   kill0      : invalidate the contents of entry 0 (squash the youngest)
//   dst_vld_in : new destination tag valid
//   dst_tag_in : new destination tag
//   src_vld    : per-source compare enable
//   src_tag    : source tags, source s at [s*TAG_W +: TAG_W]
//   match_vec  : bit [s*DEPTH+i] = source s hit entry i (registered)
//   byp_sel    : one-hot youngest match per source (registered)
//   hit        : OR of match_vec per source (registered)
// ---------------------------------------------------------------------------
module sparc_exu_ecl_tagcmp_pipe #(
  parameter int unsigned TAG_W        = 7,
  parameter int unsigned DEPTH        = 3,
  parameter int unsigned NSRC         = 3,
  parameter bit          ZERO_NOMATCH = 1'b1
) (
  input  logic                    clk,
  input  logic                    arst_l,
  input  logic                    advance,
  input  logic                    flush,
  input  logic                    kill0,
  input  logic                    dst_vld_in,
  input  logic [TAG_W-1:0]        dst_tag_in,
  input  logic [NSRC-1:0]         src_vld,
  input  logic [NSRC*TAG_W-1:0]   src_tag,
  output logic [NSRC*DEPTH-1:0]   match_vec,
  output logic [NSRC*DEPTH-1:0]   byp_sel,
  output logic [NSRC-1:0]         hit
);

  logic [DEPTH-1:0]      vld_q, vld_d;
  logic [TAG_W-1:0]      tag_q [DEPTH];
  logic [TAG_W-1:0]      tag_d [DEPTH];

  logic [NSRC*DEPTH-1:0] eq;
  logic [NSRC*DEPTH-1:0] sel;
  logic [NSRC-1:0]       hit_d;

  logic [NSRC*DEPTH-1:0] match_q, sel_q;
  logic [NSRC-1:0]       hit_q;

  // Entry next-state: flush beats advance, advance beats stall.
  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    if (flush) begin
      vld_d = '0;
    end else if (advance) begin
      vld_d[0] = dst_vld_in;
      tag_d[0] = dst_tag_in;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        tag_d[i] = tag_q[i-1];
        // kill0 squashes the youngest as it moves into entry 1.
        if (i == 1) vld_d[i] = vld_q[0] & ~kill0;
        else        vld_d[i] = vld_q[i-1];
      end
    end else begin
      vld_d[0] = vld_q[0] & ~kill0;
    end
  end

  // Compare on pre-edge entry state; kill0 and advance do not affect it.
  always_comb begin
    logic [TAG_W-1:0] src_t;
    logic             src_zero;
    eq       = '0;
    src_t    = '0;
    src_zero = 1'b0;
    for (int unsigned s = 0; s < NSRC; s++) begin
      src_t    = src_tag[s*TAG_W +: TAG_W];
      src_zero = ~|src_t;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        eq[s*DEPTH+i] = src_vld[s] & vld_q[i] & ~|(src_t ^ tag_q[i])
                        & ~(ZERO_NOMATCH & src_zero);
      end
    end
  end

  // Youngest (lowest-index) match select and hit per source.
  always_comb begin
    logic seen;
    seen  = 1'b0;
    sel   = '0;
    hit_d = '0;
    for (int unsigned s = 0; s < NSRC; s++) begin
      seen = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (eq[s*DEPTH+i] && !seen) begin
          sel[s*DEPTH+i] = 1'b1;
          seen           = 1'b1;
        end
      end
      hit_d[s] = |eq[s*DEPTH +: DEPTH];
    end
  end

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  // Tag contents are don't-care after reset; only valids are cleared.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      match_q <= '0;
      sel_q   <= '0;
      hit_q   <= '0;
    end else if (flush) begin
      match_q <= '0;
      sel_q   <= '0;
      hit_q   <= '0;
    end else begin
      match_q <= eq;
      sel_q   <= sel;
      hit_q   <= hit_d;
    end
  end

  assign match_vec = match_q;
  assign byp_sel   = sel_q;
  assign hit       = hit_q;

endmodule

// File: tb/tb_sparc_exu_ecl_tagcmp_pipe.sv
// ---------------------------------------------------------------------------
// tb_sparc_exu_ecl_tagcmp_pipe
//
// Directed bench for the tag-compare pipeline at default parameters, plus a
// second instance with ZERO_NOMATCH=0 sharing the same stimulus for the %g0
// behaviour. Outputs are sampled 1 ns after each rising edge; inputs change
// at the same point.
// ---------------------------------------------------------------------------
module tb_sparc_exu_ecl_tagcmp_pipe;

  localparam int unsigned TAG_W = 7;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned NSRC  = 3;

  logic                  clk;
  logic                  arst_l;
  logic                  advance;
  logic                  flush;
  logic                  kill0;
  logic                  dst_vld_in;
  logic [TAG_W-1:0]      dst_tag_in;
  logic [NSRC-1:0]       src_vld;
  logic [NSRC*TAG_W-1:0] src_tag;
  logic [NSRC*DEPTH-1:0] match_vec, byp_sel;
  logic [NSRC-1:0]       hit;
  logic [NSRC*DEPTH-1:0] match_vec_z, byp_sel_z;
  logic [NSRC-1:0]       hit_z;

  int checks = 0;
  int errors = 0;

  sparc_exu_ecl_tagcmp_pipe #(
    .TAG_W(TAG_W), .DEPTH(DEPTH), .NSRC(NSRC), .ZERO_NOMATCH(1'b1)
  ) u_dut (
    .clk(clk), .arst_l(arst_l), .advance(advance), .flush(flush),
    .kill0(kill0), .dst_vld_in(dst_vld_in), .dst_tag_in(dst_tag_in),
    .src_vld(src_vld), .src_tag(src_tag),
    .match_vec(match_vec), .byp_sel(byp_sel), .hit(hit)
  );

  sparc_exu_ecl_tagcmp_pipe #(
    .TAG_W(TAG_W), .DEPTH(DEPTH), .NSRC(NSRC), .ZERO_NOMATCH(1'b0)
  ) u_dut_z0 (
    .clk(clk), .arst_l(arst_l), .advance(advance), .flush(flush),
    .kill0(kill0), .dst_vld_in(dst_vld_in), .dst_tag_in(dst_tag_in),
    .src_vld(src_vld), .src_tag(src_tag),
    .match_vec(match_vec_z), .byp_sel(byp_sel_z), .hit(hit_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    advance    = 1'b0;
    flush      = 1'b0;
    kill0      = 1'b0;
    dst_vld_in = 1'b0;
    dst_tag_in = '0;
    src_vld    = '0;
    src_tag    = '0;
  endtask

  // Push one destination tag (advance for one edge), compares disabled.
  task automatic write_tag(input logic [TAG_W-1:0] t);
    idle();
    advance    = 1'b1;
    dst_vld_in = 1'b1;
    dst_tag_in = t;
    tick();
    idle();
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    tick();
    idle();
  endtask

  task automatic set_src(input logic [NSRC-1:0] v, input logic [TAG_W-1:0] t0,
                         input logic [TAG_W-1:0] t1, input logic [TAG_W-1:0] t2);
    src_vld = v;
    src_tag = {t2, t1, t0};
  endtask

  task automatic test_reset();
    idle();
    arst_l = 1'b0;
    #3;
    checks++;
    if ({hit, byp_sel, match_vec} !== 21'h0 || {hit_z, byp_sel_z, match_vec_z} !== 21'h0) begin
      errors++;
      $display("FAIL reset_assert: got %h/%h required 0", {hit, byp_sel, match_vec}, {hit_z, byp_sel_z, match_vec_z});
    end
    tick();
    tick();
    arst_l = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++;
      if ({hit, byp_sel, match_vec} !== 21'h0 || {hit_z, byp_sel_z, match_vec_z} !== 21'h0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: got %h/%h required 0", n, {hit, byp_sel, match_vec}, {hit_z, byp_sel_z, match_vec_z});
      end
    end
  endtask

  task automatic test_shift_match();
    logic [8:0] exp_m [4];
    logic [2:0] exp_h [4];
    exp_m[0] = 9'b000_000_001; exp_h[0] = 3'b001;
    exp_m[1] = 9'b000_000_010; exp_h[1] = 3'b001;
    exp_m[2] = 9'b000_000_100; exp_h[2] = 3'b001;
    exp_m[3] = 9'b000_000_000; exp_h[3] = 3'b000;
    do_flush();
    write_tag(7'h15);
    for (int n = 0; n < 4; n++) begin
      set_src(3'b001, 7'h15, 7'h00, 7'h00);
      tick();
      checks++;
      if (match_vec !== exp_m[n] || byp_sel !== exp_m[n] || hit !== exp_h[n]) begin
        errors++;
        $display("FAIL shift_match[%0d]: match=%b byp=%b hit=%b required match=%b byp=%b hit=%b",
                 n, match_vec, byp_sel, hit, exp_m[n], exp_m[n], exp_h[n]);
      end
      idle();
      advance = 1'b1;
      tick();
      idle();
    end
  endtask

  task automatic test_youngest();
    do_flush();
    write_tag(7'h0A);
    write_tag(7'h0A);
    set_src(3'b010, 7'h00, 7'h0A, 7'h00);
    tick();
    checks++;
    if (match_vec !== 9'b000_011_000 || byp_sel !== 9'b000_001_000 || hit !== 3'b010) begin
      errors++;
      $display("FAIL youngest: match=%b byp=%b hit=%b required 000011000/000001000/010", match_vec, byp_sel, hit);
    end
    // Two sources with the same tag give identical results; src2 misses.
    set_src(3'b111, 7'h0A, 7'h0A, 7'h0B);
    tick();
    checks++;
    if (match_vec !== 9'b000_011_011 || byp_sel !== 9'b000_001_001 || hit !== 3'b011) begin
      errors++;
      $display("FAIL same_src: match=%b byp=%b hit=%b required 000011011/000001001/011", match_vec, byp_sel, hit);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    // e0=06, e1=05, e2=0A: selects land on older entries.
    do_flush();
    write_tag(7'h0A);
    write_tag(7'h05);
    write_tag(7'h06);
    set_src(3'b111, 7'h0A, 7'h05, 7'h06);
    tick();
    checks++;
    if (match_vec !== 9'b001_010_100 || byp_sel !== 9'b001_010_100 || hit !== 3'b111) begin
      errors++;
      $display("FAIL back_to_back: match=%b byp=%b hit=%b required 001010100/001010100/111", match_vec, byp_sel, hit);
    end
    // src_vld gating: same tags, only src1 enabled.
    set_src(3'b010, 7'h0A, 7'h05, 7'h06);
    tick();
    checks++;
    if (match_vec !== 9'b000_010_000 || byp_sel !== 9'b000_010_000 || hit !== 3'b010) begin
      errors++;
      $display("FAIL src_vld_gate: match=%b byp=%b hit=%b required 000010000/000010000/010", match_vec, byp_sel, hit);
    end
    idle();
  endtask

  task automatic test_zero_tag();
    do_flush();
    write_tag(7'h00);
    set_src(3'b001, 7'h00, 7'h00, 7'h00);
    tick();
    checks++;
    if (hit !== 3'b000 || match_vec !== 9'b0) begin
      errors++;
      $display("FAIL zero_nomatch1: match=%b hit=%b required 0/000", match_vec, hit);
    end
    checks++;
    if (hit_z !== 3'b001 || match_vec_z !== 9'b000_000_001 || byp_sel_z !== 9'b000_000_001) begin
      errors++;
      $display("FAIL zero_nomatch0: match=%b byp=%b hit=%b required 000000001/000000001/001", match_vec_z, byp_sel_z, hit_z);
    end
    idle();
  endtask

  task automatic test_stall_kill();
    do_flush();
    write_tag(7'h33);
    for (int n = 0; n < 3; n++) begin
      dst_vld_in = 1'b1;
      dst_tag_in = 7'h44;
      set_src(3'b011, 7'h33, 7'h44, 7'h00);
      tick();
      checks++;
      if (match_vec !== 9'b000_000_001 || hit !== 3'b001) begin
        errors++;
        $display("FAIL stall[%0d]: match=%b hit=%b required 000000001/001", n, match_vec, hit);
      end
    end
    idle();
    // kill0 does not mask the same-cycle compare.
    kill0 = 1'b1;
    set_src(3'b001, 7'h33, 7'h00, 7'h00);
    tick();
    checks++;
    if (hit !== 3'b001) begin
      errors++;
      $display("FAIL kill_same_cycle: hit=%b required 001", hit);
    end
    kill0 = 1'b0;
    tick();
    checks++;
    if (hit !== 3'b000 || match_vec !== 9'b0) begin
      errors++;
      $display("FAIL kill_stall: match=%b hit=%b required 0/000", match_vec, hit);
    end
    // kill0 during advance invalidates the entry as it moves to entry 1.
    write_tag(7'h55);
    advance = 1'b1;
    kill0   = 1'b1;
    tick();
    idle();
    set_src(3'b001, 7'h55, 7'h00, 7'h00);
    tick();
    checks++;
    if (hit !== 3'b000 || match_vec !== 9'b0) begin
      errors++;
      $display("FAIL kill_advance: match=%b hit=%b required 0/000", match_vec, hit);
    end
    idle();
  endtask

  task automatic test_flush();
    do_flush();
    write_tag(7'h11);
    write_tag(7'h22);
    write_tag(7'h33);
    set_src(3'b111, 7'h11, 7'h22, 7'h33);
    tick();
    checks++;
    if (match_vec !== 9'b001_010_100 || byp_sel !== 9'b001_010_100 || hit !== 3'b111) begin
      errors++;
      $display("FAIL flush_prefill: match=%b byp=%b hit=%b required 001010100/001010100/111", match_vec, byp_sel, hit);
    end
    flush      = 1'b1;
    advance    = 1'b1;
    dst_vld_in = 1'b1;
    dst_tag_in = 7'h44;
    tick();
    checks++;
    if ({hit, byp_sel, match_vec} !== 21'h0) begin
      errors++;
      $display("FAIL flush_outputs: got %h required 0", {hit, byp_sel, match_vec});
    end
    flush      = 1'b0;
    advance    = 1'b0;
    dst_vld_in = 1'b0;
    tick();
    checks++;
    if ({hit, byp_sel, match_vec} !== 21'h0) begin
      errors++;
      $display("FAIL flush_old_tags: got %h required 0", {hit, byp_sel, match_vec});
    end
    set_src(3'b111, 7'h44, 7'h44, 7'h44);
    tick();
    checks++;
    if ({hit, byp_sel, match_vec} !== 21'h0) begin
      errors++;
      $display("FAIL flush_new_tag: got %h required 0", {hit, byp_sel, match_vec});
    end
    idle();
  endtask

  task automatic test_async_reset();
    do_flush();
    write_tag(7'h5A);
    set_src(3'b001, 7'h5A, 7'h00, 7'h00);
    tick();
    checks++;
    if (hit !== 3'b001) begin
      errors++;
      $display("FAIL async_pre: hit=%b required 001", hit);
    end
    #2 arst_l = 1'b0;
    #1;
    checks++;
    if ({hit, byp_sel, match_vec} !== 21'h0) begin
      errors++;
      $display("FAIL async_immediate: got %h required 0", {hit, byp_sel, match_vec});
    end
    #2 arst_l = 1'b1;
    tick();
    checks++;
    if ({hit, byp_sel, match_vec} !== 21'h0) begin
      errors++;
      $display("FAIL async_entries_cleared: got %h required 0", {hit, byp_sel, match_vec});
    end
    idle();
  endtask

  initial begin
    idle();
    arst_l = 1'b0;
    test_reset();
    test_shift_match();
    test_youngest();
    test_back_to_back();
    test_zero_tag();
    test_stall_kill();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
